// File: rtl/vid_pkg.sv
// vid_pkg: shared types, colour-bar constants and timing helpers for the
// video output pipeline.
//   pixel_t    : 24-bit RGB pixel, R[23:16] G[15:8] B[7:0]
//   state_t    : stream-to-raster lock state (IDLE, SEEK, RUN)
//   BAR_*      : colour-bar palette used by the optional test-pattern source
//   total()    : sum of active + front porch + sync + back porch
//   bar_color(): maps a bar index 0..7 to its colour
package vid_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
  localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
  localparam pixel_t BAR_CYAN    = 24'h00FFFF;
  localparam pixel_t BAR_GREEN   = 24'h00FF00;
  localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
  localparam pixel_t BAR_RED     = 24'hFF0000;
  localparam pixel_t BAR_BLUE    = 24'h0000FF;
  localparam pixel_t BAR_BLACK   = 24'h000000;

  function automatic int total(input int active, input int fp, input int sw, input int bp);
    return active + fp + sw + bp;
  endfunction

  function automatic pixel_t bar_color(input logic [2:0] idx);
    pixel_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// vid_timing_cnt: horizontal/vertical raster counters with region decode.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   enable       : counters run when 1, are held at 0 when 0
//   h_cnt, v_cnt : current raster position
//   active_now   : position is inside the active picture
//   hsync_now    : position is inside the horizontal sync pulse (polarity-free)
//   vsync_now    : line is inside the vertical sync pulse (polarity-free)
// Decode outputs are combinational from the counters; consumers register them.
module vid_timing_cnt
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SW     = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SW     = 5,
  parameter int V_BP     = 36,
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SW, H_BP),
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SW, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active_now,
  output logic          hsync_now,
  output logic          vsync_now
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SW;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Compare in 32 bits: sync end may equal the total, which need not fit in HW/VW.
  logic [31:0] h_ext;
  logic [31:0] v_ext;
  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  assign active_now = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
  assign hsync_now  = (h_ext >= 32'(HS_START)) && (h_ext < 32'(HS_END));
  assign vsync_now  = (v_ext >= 32'(VS_START)) && (v_ext < 32'(VS_END));

endmodule

// File: rtl/vid_stream_to_timing.sv
// vid_stream_to_timing: converts an AXI4-Stream video feed (tuser = start of
// frame, tlast = end of line) into free-running raster video. The raster never
// stalls; the stream is back-pressured and re-aligned to the raster origin.
//   clk, rst_n            : pixel clock, asynchronous active-low reset
//   enable                : run the raster; 0 holds counters and idles outputs
//   s_axis_*              : stream input (tdata/tvalid/tready/tuser/tlast)
//   vid_data/hsync/vsync/de : registered raster outputs to the encoder
//   locked                : stream is aligned to the raster (state RUN)
//   underflow             : sticky, an active pixel had no stream data
//   sync_err              : sticky, tuser/tlast arrived misaligned
//   clr_status            : single-cycle clear of both sticky flags
// Optional build macro VID_TPG_EN adds input tpg_sel, which replaces the
// picture with 8 vertical colour bars and keeps the stream side parked.
//
// state | meaning
// IDLE  | disabled, or first enabled cycle; stream side not accepting
// SEEK  | dropping non-SOF beats, waiting for tuser at raster (0,0)
// RUN   | stream aligned; one beat consumed per active pixel
module vid_stream_to_timing
  import vid_pkg::*;
#(
  parameter int VID_H_ACTIVE      = 1920,
  parameter int VID_H_FRONT_PORCH = 88,
  parameter int VID_H_SYNC_WIDTH  = 44,
  parameter int VID_H_BACK_PORCH  = 148,
  parameter int VID_V_ACTIVE      = 1080,
  parameter int VID_V_FRONT_PORCH = 4,
  parameter int VID_V_SYNC_WIDTH  = 5,
  parameter int VID_V_BACK_PORCH  = 36,
  parameter int DATA_WIDTH        = 24,
  parameter bit SYNC_POL          = 1'b1,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 24'h0000FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
`ifdef VID_TPG_EN
  input  logic                  tpg_sel,
`endif
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_hsync,
  output logic                  vid_vsync,
  output logic                  vid_de,
  output logic                  locked,
  output logic                  underflow,
  output logic                  sync_err,
  input  logic                  clr_status
);

  localparam int H_TOTAL = total(VID_H_ACTIVE, VID_H_FRONT_PORCH, VID_H_SYNC_WIDTH, VID_H_BACK_PORCH);
  localparam int V_TOTAL = total(VID_V_ACTIVE, VID_V_FRONT_PORCH, VID_V_SYNC_WIDTH, VID_V_BACK_PORCH);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST_PX = HW'(VID_H_ACTIVE - 1);
  localparam logic          SYNC_IDLE = ~SYNC_POL;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  active_now;
  logic                  hsync_now;
  logic                  vsync_now;

  state_t                state;
  state_t                state_nxt;
  logic                  tpg_on;
  logic                  at_origin;
  logic                  beat_take;
  logic                  lock_evt;
  logic                  err_evt;
  logic                  uf_evt;
  logic [DATA_WIDTH-1:0] pix_nxt;

  vid_timing_cnt #(
    .H_ACTIVE (VID_H_ACTIVE),
    .H_FP     (VID_H_FRONT_PORCH),
    .H_SW     (VID_H_SYNC_WIDTH),
    .H_BP     (VID_H_BACK_PORCH),
    .V_ACTIVE (VID_V_ACTIVE),
    .V_FP     (VID_V_FRONT_PORCH),
    .V_SW     (VID_V_SYNC_WIDTH),
    .V_BP     (VID_V_BACK_PORCH)
  ) u_timing_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active_now (active_now),
    .hsync_now  (hsync_now),
    .vsync_now  (vsync_now)
  );

`ifdef VID_TPG_EN
  assign tpg_on = tpg_sel;
`else
  assign tpg_on = 1'b0;
`endif

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign locked    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SEEK;
      SEEK:    if (lock_evt) state_nxt = RUN;
      RUN:     if (err_evt || tpg_on) state_nxt = SEEK;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_comb begin
    s_axis_tready = 1'b0;
    beat_take     = 1'b0;
    lock_evt      = 1'b0;
    err_evt       = 1'b0;
    uf_evt        = 1'b0;
    if (enable && !tpg_on) begin
      case (state)
        SEEK: begin
          // SOF beat is held until the raster origin, everything else is drained.
          if (at_origin && s_axis_tvalid && s_axis_tuser) begin
            s_axis_tready = 1'b1;
            lock_evt      = 1'b1;
          end else begin
            s_axis_tready = s_axis_tvalid && !s_axis_tuser;
          end
        end
        RUN: begin
          s_axis_tready = active_now;
          beat_take     = active_now && s_axis_tvalid;
          uf_evt        = active_now && !s_axis_tvalid;
          // tlast must coincide exactly with the last active pixel of the line.
          err_evt       = beat_take &&
                          ((s_axis_tlast != (h_cnt == H_LAST_PX)) ||
                           (s_axis_tuser && !at_origin));
        end
        default: ;
      endcase
    end
  end

`ifdef VID_TPG_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((32'(h_cnt) * 32'd8) / 32'(VID_H_ACTIVE));
`endif

  always_comb begin
    pix_nxt = '0;
    if (active_now) begin
      if (lock_evt || beat_take) pix_nxt = s_axis_tdata;
      else                       pix_nxt = UNDERFLOW_COLOR;
`ifdef VID_TPG_EN
      if (tpg_on) pix_nxt = DATA_WIDTH'(bar_color(bar_idx));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_data  <= '0;
      vid_de    <= 1'b0;
      vid_hsync <= SYNC_IDLE;
      vid_vsync <= SYNC_IDLE;
    end else if (!enable) begin
      vid_data  <= '0;
      vid_de    <= 1'b0;
      vid_hsync <= SYNC_IDLE;
      vid_vsync <= SYNC_IDLE;
    end else begin
      vid_data  <= pix_nxt;
      vid_de    <= active_now;
      vid_hsync <= hsync_now ^ SYNC_IDLE;
      vid_vsync <= vsync_now ^ SYNC_IDLE;
    end
  end

  // A new event in the same cycle as clr_status wins, so the flag stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (clr_status) begin
        underflow <= 1'b0;
        sync_err  <= 1'b0;
      end
      if (uf_evt)  underflow <= 1'b1;
      if (err_evt) sync_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vid_stream_to_timing.sv
module tb_vid_stream_to_timing;

  localparam int HA = 8;
  localparam int HT = 14;
  localparam int VA = 4;
  localparam int VT = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        tpg_sel;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic [23:0] vid_data;
  logic        vid_hsync;
  logic        vid_vsync;
  logic        vid_de;
  logic        locked;
  logic        underflow;
  logic        sync_err;
  logic        clr_status;

  always #5 clk = ~clk;

  vid_stream_to_timing #(
    .VID_H_ACTIVE      (8),
    .VID_H_FRONT_PORCH (2),
    .VID_H_SYNC_WIDTH  (2),
    .VID_H_BACK_PORCH  (2),
    .VID_V_ACTIVE      (4),
    .VID_V_FRONT_PORCH (1),
    .VID_V_SYNC_WIDTH  (1),
    .VID_V_BACK_PORCH  (1),
    .DATA_WIDTH        (24),
    .SYNC_POL          (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
`ifdef VID_TPG_EN
    .tpg_sel       (tpg_sel),
`endif
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .vid_data      (vid_data),
    .vid_hsync     (vid_hsync),
    .vid_vsync     (vid_vsync),
    .vid_de        (vid_de),
    .locked        (locked),
    .underflow     (underflow),
    .sync_err      (sync_err),
    .clr_status    (clr_status)
  );

  int n_vec = 0;
  int n_bad = 0;
  int k     = -1;   // raster index (since enable) whose outputs are now visible

  // stream source
  int beat_ptr     = 0;
  int junk_n       = 0;
  int force_last_i = -1;
  bit valid_on     = 1'b0;

  // scenario expectations
  int gap_a    = -10;
  int gap_b    = -10;
  int lock_k   = -1;
  int err_k    = -1;
  int relock_k = -1;
  int uf_k     = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic drive_beat(input bit gap);
    int i;
    if (gap) beat_ptr++;
    s_axis_tvalid = valid_on && !gap;
    if (beat_ptr < junk_n) begin
      s_axis_tdata = 24'hA00000 | 24'(beat_ptr);
      s_axis_tuser = 1'b0;
      s_axis_tlast = 1'b0;
    end else begin
      i = beat_ptr - junk_n;
      s_axis_tdata = 24'(i % 32);
      s_axis_tuser = (i % 32 == 0);
      s_axis_tlast = (i % 8 == 7) || (i == force_last_i);
    end
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = s_axis_tvalid && s_axis_tready;
    @(posedge clk);
    #1;
    k++;
    if (acc) beat_ptr++;
  endtask

  function automatic bit in_run(input int kk);
    return (lock_k >= 0 && kk >= lock_k && (err_k < 0 || kk < err_k)) ||
           (relock_k >= 0 && kk >= relock_k);
  endfunction

  task automatic check_raster();
    int h;
    int v;
    bit act;
    bit strm;
    logic [23:0] exp_d;
    h    = k % HT;
    v    = (k / HT) % VT;
    act  = (h < HA) && (v < VA);
    strm = (in_run(k) || (err_k >= 0 && k == err_k)) && !(k >= gap_a && k <= gap_b);
    exp_d = act ? (strm ? 24'(v * 8 + h) : 24'h0000FF) : 24'h0;
    check("de",        32'(vid_de),    32'(act));
    check("hsync",     32'(vid_hsync), 32'(h == 10 || h == 11));
    check("vsync",     32'(vid_vsync), 32'(v == 5));
    check("data",      32'(vid_data),  32'(exp_d));
    check("locked",    32'(locked),    32'(in_run(k)));
    check("underflow", 32'(underflow), 32'(uf_k >= 0 && k >= uf_k));
    check("sync_err",  32'(sync_err),  32'(err_k >= 0 && k >= err_k));
  endtask

  task automatic run_to(input int kend);
    while (k < kend) begin
      drive_beat((k + 1 >= gap_a) && (k + 1 <= gap_b));
      step();
      check_raster();
    end
  endtask

  task automatic restart(input bit do_rst);
    enable        = 1'b0;
    clr_status    = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    step();
    if (do_rst) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
    end
    k        = -1;
    beat_ptr = 0;
    gap_a    = -10;
    gap_b    = -10;
    enable   = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    tpg_sel       = 1'b0;
    clr_status    = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",   32'(vid_data),      32'h0);
    check("rst_de",     32'(vid_de),        32'h0);
    check("rst_hsync",  32'(vid_hsync),     32'h0);
    check("rst_vsync",  32'(vid_vsync),     32'h0);
    check("rst_tready", 32'(s_axis_tready), 32'h0);
    check("rst_locked", 32'(locked),        32'h0);
    check("rst_uf",     32'(underflow),     32'h0);
    check("rst_serr",   32'(sync_err),      32'h0);
    rst_n = 1'b1;

    // free-running raster with no stream data
    valid_on = 1'b0; lock_k = -1; err_k = -1; relock_k = -1; uf_k = -1;
    restart(1'b1);
    run_to(97);

    // continuous stream, lock on frame 1, two lost beats on line 1 pixels 3-4
    valid_on = 1'b1; junk_n = 0; force_last_i = -1;
    lock_k = 98; err_k = -1; relock_k = -1; uf_k = 115;
    restart(1'b1);
    gap_a = 115; gap_b = 116;
    run_to(293);

    // early tlast at pixel 5: drop lock, drain, relock at next frame origin
    force_last_i = 5;
    lock_k = 98; err_k = 103; relock_k = 196; uf_k = -1;
    restart(1'b1);
    run_to(212);

    // status clear, clear-vs-set collision, mid-line disable
    drive_beat(1'b1);
    step();
    check("uf_set",    32'(underflow), 32'h1);
    check("serr_held", 32'(sync_err),  32'h1);
    check("uf_data",   32'(vid_data),  32'h0000FF);
    check("uf_lock",   32'(locked),    32'h1);
    clr_status = 1'b1;
    drive_beat(1'b0);
    step();
    check("clr_uf",    32'(underflow), 32'h0);
    check("clr_serr",  32'(sync_err),  32'h0);
    check("clr_data",  32'(vid_data),  32'd12);
    drive_beat(1'b1);
    step();
    check("clr_vs_set_uf",   32'(underflow), 32'h1);
    check("clr_vs_set_serr", 32'(sync_err),  32'h0);
    clr_status = 1'b0;
    drive_beat(1'b0);
    step();
    check("resume_data", 32'(vid_data), 32'd14);
    enable = 1'b0;
    drive_beat(1'b0);
    step();
    check("dis_de",     32'(vid_de),        32'h0);
    check("dis_hsync",  32'(vid_hsync),     32'h0);
    check("dis_vsync",  32'(vid_vsync),     32'h0);
    check("dis_data",   32'(vid_data),      32'h0);
    check("dis_locked", 32'(locked),        32'h0);
    check("dis_tready", 32'(s_axis_tready), 32'h0);
    check("dis_uf",     32'(underflow),     32'h1);
    valid_on = 1'b0; force_last_i = -1;
    lock_k = -1; err_k = -1; relock_k = -1; uf_k = 0;
    restart(1'b0);
    run_to(20);

    // 20 junk beats ahead of the start-of-frame beat
    valid_on = 1'b1; junk_n = 20; force_last_i = -1;
    lock_k = 98; err_k = -1; relock_k = -1; uf_k = -1;
    restart(1'b1);
    run_to(130);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
